// File: rtl/mac_array_ctrl.sv
// Sequencer for the 2-D MAC array: KLOAD/EXEC/FLUSH/DRAIN phases, skewed row instructions.
// Optional cycle counter output enabled by `define MAC_CTRL_PERF_CNT_EN.
module mac_array_ctrl #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int len_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [len_bw-1:0] num_vec,
    output logic [2*row-1:0]  inst_w,
    output logic              mode_o,
    output logic              rd_en,
    output logic              drain_en,
    output logic              busy,
    output logic              done
`ifdef MAC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int FL_LEN = row + col - 1;
    localparam int M1     = (col > FL_LEN) ? col : FL_LEN;
    localparam int N_MAX  = (1 << len_bw) - 1;
    localparam int M2     = (M1 > N_MAX) ? M1 : N_MAX;
    localparam int CW     = $clog2(M2 + 1);

    localparam logic [CW-1:0] KL_LAST = CW'(col - 1);
    localparam logic [CW-1:0] FL_LAST = CW'(FL_LEN - 1);
    localparam logic [CW-1:0] DR_LAST = CW'(row - 1);

    typedef enum logic [2:0] {
        IDLE,
        KLOAD,
        EXEC,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [len_bw-1:0] n_q;
    logic              m_q;
    logic [1:0]        base;
    logic [2*row-1:0]  chain;
    logic              accept;

    assign accept = (state == IDLE) && start;

    always_comb begin
        state_nxt = state;
        base      = 2'b00;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (!mode)
                        state_nxt = KLOAD;
                    else if (num_vec == '0)
                        state_nxt = FLUSH;
                    else
                        state_nxt = EXEC;
                end
            end
            KLOAD: begin
                base = 2'b01;
                if (cnt == KL_LAST)
                    state_nxt = (n_q == '0) ? FLUSH : EXEC;
            end
            EXEC: begin
                base = 2'b10;
                if (cnt == CW'(n_q) - CW'(1))
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                if (cnt == FL_LAST)
                    state_nxt = m_q ? DRAIN : DONE;
            end
            DRAIN: begin
                if (cnt == DR_LAST)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            n_q   <= '0;
            m_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            // counter restarts at zero on every phase entry
            if (state == IDLE || state_nxt != state)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (accept) begin
                n_q <= num_vec;
                m_q <= mode;
            end
        end
    end

    // row r sees row 0's instruction r cycles later
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain[1:0] <= base;
            for (int r = 1; r < row; r++)
                chain[2*r+:2] <= chain[2*(r-1)+:2];
        end
    end

    assign inst_w   = chain;
    assign mode_o   = m_q;
    assign rd_en    = (state == KLOAD) || (state == EXEC);
    assign drain_en = (state == DRAIN);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

`ifdef MAC_CTRL_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset)
            perf_q <= '0;
        else if (accept)
            perf_q <= '0;
        else if (busy && perf_q != '1)
            perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: phase-arithmetic reference model,
// per-cycle expectations queued at each edge and checked at the falling edge.
module tb_mac_array_ctrl;

    localparam int ROW  = 8;
    localparam int COL  = 8;
    localparam int LBW  = 8;
    localparam int MAXC = 8192;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            mode = 1'b0;
    logic [LBW-1:0]  num_vec = '0;
    logic [2*ROW-1:0] inst_w;
    logic            mode_o, rd_en, drain_en, busy, done;
`ifdef MAC_CTRL_PERF_CNT_EN
    logic [31:0]     perf_cycles;
`endif

    mac_array_ctrl #(.row(ROW), .col(COL), .len_bw(LBW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mode(mode),
        .num_vec(num_vec),
        .inst_w(inst_w),
        .mode_o(mode_o),
        .rd_en(rd_en),
        .drain_en(drain_en),
        .busy(busy),
        .done(done)
`ifdef MAC_CTRL_PERF_CNT_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [2*ROW-1:0] inst;
        logic             mo;
        logic             rd;
        logic             dr;
        logic             bz;
        logic             dn;
        logic [31:0]      perf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [1:0] base_hist [MAXC];
    bit         rst_hist  [MAXC];

    bit          active = 0;
    int          js = 0;
    bit          jm = 0;
    int          jn = 0;
    int          jlen = 0;
    bit          mode_m = 0;
    logic [31:0] perf_m = '0;

    // Spec-level phase map for offset k after the accepting edge
    function automatic void ref_phase(input int k, input bit m, input int n,
                                      output logic [1:0] b, output logic rd,
                                      output logic dr, output logic bz,
                                      output logic dn);
        int kl, ex, fl, dre, dat;
        kl  = m ? 0 : COL;
        ex  = kl + n;
        fl  = ex + ROW + COL - 1;
        dre = m ? fl + ROW : fl;
        dat = dre + 1;
        b = 2'b00; rd = 0; dr = 0; bz = 0; dn = 0;
        if (k >= 1 && k <= dat) bz = 1;
        if (k >= 1 && k <= kl) begin
            b = 2'b01; rd = 1;
        end else if (k > kl && k <= ex) begin
            b = 2'b10; rd = 1;
        end else if (k > fl && k <= dre) begin
            dr = 1;
        end else if (k == dat) begin
            dn = 1;
        end
    endfunction

    always @(posedge clk) begin : model
        exp_t       r;
        int         c;
        bit         busy_e;
        logic [1:0] b;
        bit         clean;
        int         idx;
        if (cyc < MAXC - 1) begin
            rst_hist[cyc] = reset;
            busy_e = active && (cyc - js) >= 1 && (cyc - js) <= jlen;
            if (reset) begin
                active = 0;
                mode_m = 0;
                perf_m = '0;
            end else if (!busy_e && start) begin
                active = 1;
                js     = cyc;
                jm     = mode;
                jn     = int'(num_vec);
                jlen   = jm ? jn + 2*ROW + COL : 2*COL + jn + ROW;
                mode_m = mode;
                perf_m = '0;
            end else if (busy_e && perf_m != '1) begin
                perf_m = perf_m + 32'd1;
            end
            c = cyc + 1;
            r.cyc = c;
            r.bz = 0; r.rd = 0; r.dr = 0; r.dn = 0; b = 2'b00;
            if (active)
                ref_phase(c - js, jm, jn, b, r.rd, r.dr, r.bz, r.dn);
            base_hist[c] = b;
            r.inst = '0;
            for (int rr = 0; rr < ROW; rr++) begin
                idx = c - 1 - rr;
                if (idx >= 0) begin
                    clean = 1;
                    for (int t = idx; t <= c - 1; t++)
                        if (rst_hist[t]) clean = 0;
                    if (clean) r.inst[2*rr+:2] = base_hist[idx];
                end
            end
            r.mo   = mode_m;
            r.perf = perf_m;
            q.push_back(r);
            cyc = c;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t r;
        logic [31:0] pv;
        if (q.size() > 0) begin
            r = q.pop_front();
`ifdef MAC_CTRL_PERF_CNT_EN
            pv = perf_cycles;
`else
            pv = r.perf;
`endif
            checks++;
            if (inst_w !== r.inst || mode_o !== r.mo || rd_en !== r.rd ||
                drain_en !== r.dr || busy !== r.bz || done !== r.dn ||
                pv !== r.perf) begin
                errors++;
                $display("FAIL cycle%0d got inst=%h mo=%b rd=%b dr=%b busy=%b done=%b perf=%0d want inst=%h mo=%b rd=%b dr=%b busy=%b done=%b perf=%0d",
                         r.cyc, inst_w, mode_o, rd_en, drain_en, busy, done, pv,
                         r.inst, r.mo, r.rd, r.dr, r.bz, r.dn, r.perf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input bit m, input int n, input int exp_len,
                           input string name);
        int s;
        int got;
        got     = -1;
        s       = cyc;
        start   = 1'b1;
        mode    = m;
        num_vec = LBW'(n);
        tick();
        start   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                got = cyc - s;
                break;
            end
            tick();
        end
        checks++;
        if (got != exp_len) begin
            errors++;
            $display("FAIL %s done_cycle got %0d want %0d", name, got, exp_len);
        end
        tick();
    endtask

    initial begin
        int s;
        int ndone;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        run_job(0, 4, 28, "ws_n4");
`ifdef MAC_CTRL_PERF_CNT_EN
        checks++;
        if (perf_cycles !== 32'd28) begin
            errors++;
            $display("FAIL perf_after_done got %0d want 28", perf_cycles);
        end
        repeat (3) tick();
        checks++;
        if (perf_cycles !== 32'd28) begin
            errors++;
            $display("FAIL perf_hold got %0d want 28", perf_cycles);
        end
`endif
        tick();
        run_job(1, 3, 27, "os_n3");
        run_job(0, 0, 24, "ws_n0");
        run_job(1, 0, 24, "os_n0");
        run_job(0, 255, 2*COL + 255 + ROW, "ws_nmax");

        // abort mid-job, then restart two cycles later
        s       = cyc;
        start   = 1'b1;
        mode    = 1'b0;
        num_vec = 8'd4;
        tick();
        start = 1'b0;
        while (cyc < s + 6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        run_job(0, 4, 28, "restart_after_reset");

        // start held high: back-to-back WS N=2 jobs, inputs jittered mid-job
        start   = 1'b1;
        mode    = 1'b0;
        num_vec = 8'd2;
        ndone   = 0;
        repeat (135) begin
            tick();
            if (done) ndone++;
            if (busy && !done) begin
                mode    = 1'($urandom);
                num_vec = LBW'($urandom);
            end else begin
                mode    = 1'b0;
                num_vec = 8'd2;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 5) begin
            errors++;
            $display("FAIL back_to_back done_count got %0d want 5", ndone);
        end
        repeat (30) tick();

        // random stream: starts, mode/N changes and occasional resets
        repeat (1500) begin
            start   = ($urandom_range(0, 3) == 0);
            mode    = 1'($urandom);
            num_vec = LBW'($urandom_range(0, 20));
            reset   = ($urandom_range(0, 59) == 0);
            tick();
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (80) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencer for the 2-D MAC array built from `mac_row` instances. It accepts a job (mode plus vector count) and runs the weight-load, execute, flush and drain phases. It drives the 2-bit per-row instruction bus with the one-cycle-per-row skew the array needs, and raises SRAM read and drain strobes. It sits between the top-level core FSM and the array/L0/OFIFO.

## Interface

**Parameters**

- `row`, default 8: number of `mac_row` instances.
- `col`, default 8: MAC tiles per row.
- `len_bw`, default 8: width of the vector count.

**Ports**

- `clk`  in  1: clock. One clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: job request. Sampled only in IDLE.
- `mode`  in  1: 0 = weight-stationary (WS), 1 = output-stationary (OS). Latched at start.
- `num_vec`  in  `len_bw`: number of activation vectors N. Latched at start.
- `inst_w`  out  `2*row`: row r instruction at `[2r+:2]`. Bit 1 = execute, bit 0 = kernel load.
- `mode_o`  out  1: latched mode, to all rows.
- `rd_en`  out  1: input SRAM/L0 read strobe. High in KLOAD and EXEC.
- `drain_en`  out  1: tile_row_out capture strobe (OS only).
- `busy`  out  1: high in every state other than IDLE.
- `done`  out  1: one-cycle pulse at job end.

## Operation

**States:** IDLE, KLOAD, EXEC, FLUSH, DRAIN, DONE.

**Transitions:**

- IDLE → KLOAD on start when mode=0.
- IDLE → EXEC on start when mode=1.
- KLOAD → EXEC after `col` cycles. Goes directly to FLUSH if N=0.
- EXEC → FLUSH after N cycles.
- FLUSH → DONE after `row+col-1` cycles when mode=0.
- FLUSH → DRAIN after `row+col-1` cycles when mode=1.
- DRAIN → DONE after `row` cycles.
- DONE → IDLE after 1 cycle.

**Instruction generation:**

- Base instruction = 01 in KLOAD, 10 in EXEC, 00 otherwise.
- Row 0 receives the base instruction registered, i.e. one cycle after the state.
- Row r receives row 0's value delayed by r further cycles, via a shift chain of `row` 2-bit registers.

**Boundary rules:**

- The phase counter is `max(col, row+col-1, N)`-capable. It clears on every state entry.
- N=0 in OS mode: IDLE → FLUSH directly.
- start while busy: ignored. No queueing.
- start in the same cycle as DONE: ignored. It is accepted only once the FSM is back in IDLE.
- reset mid-job: the FSM goes to IDLE, the counter and the whole shift chain clear on the same edge, and all outputs return to reset values the next cycle. No partial instructions remain on the bus.
- mode/num_vec changes while busy have no effect.

## Timing

- Reset values: all outputs 0, including the whole `inst_w` bus.
- start is sampled at edge 0. The new state is visible in cycle 1.

**WS, N vectors:**

- `rd_en` high in cycles 1..col+N.
- Row 0 instruction: 01 in cycles 2..col+1, then 10 in cycles col+2..col+N+1.
- Row r: same sequence shifted by +r cycles.
- FLUSH spans cycles col+N+1..2col+N+row-1.
- `done` is high in cycle 2col+N+row.
- `busy` is high in cycles 1..2col+N+row.

**OS:**

- EXEC in cycles 1..N, then FLUSH of `row+col-1` cycles.
- `drain_en` high for `row` cycles.
- `done` follows on the next cycle.

**Other timing rules:**

- `rd_en` leads the row 0 instruction by exactly 1 cycle. This matches the 1-cycle SRAM read latency.
- `valid` from the rows is not consumed. Completion is decided by the counters only.

## Configuration

- Macro: `MAC_CTRL_PERF_CNT_EN`.
- When defined:
  - Adds output `perf_cycles`, 32 bits.
  - Clears on accepted start and increments every busy cycle.
  - Holds its value in IDLE. Reset value 0.
  - Saturates at all-ones.
- When undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan

1. WS, row=col=8, N=4, start at cycle 0:
   - `inst_w[1:0]` = 01 in cycles 2–9 and 10 in cycles 10–13.
   - `inst_w[15:14]` = 01 in cycles 9–16 and 10 in cycles 17–20.
   - `done` in cycle 28. `busy` is high in cycles 1–28.
2. OS, N=3:
   - No 01 instruction ever appears.
   - `inst_w[1:0]` = 10 in cycles 2–4.
   - FLUSH lasts 15 cycles, then `drain_en` is high for 8 cycles.
   - `done` in cycle 27.
3. N=0, WS:
   - Only KLOAD is issued: 8 cycles of 01.
   - No 10 appears on any row.
   - `done` in cycle 24.
4. Reset asserted in cycle 6 of a WS job:
   - From cycle 7, all `inst_w` bits, `rd_en`, `busy` and `done` are 0.
   - A new start in cycle 8 reproduces scenario 1 timing offset by 8 cycles.
5. start held high continuously, N=2, WS:
   - Jobs run back to back with exactly one IDLE cycle between `done` and the next cycle-1 KLOAD.
   - mode and N changes mid-job are ignored.
6. With `MAC_CTRL_PERF_CNT_EN` defined, scenario 1 gives `perf_cycles` = 28 after `done`, and the value holds while IDLE.
